// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and response codes for the APB command master.
package apb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;
    localparam logic APB_OK  = 1'b0;
    localparam logic APB_ERR = 1'b1;
endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response stream plus APB3 bus, with master (DUT) and slave (environment) views.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic [15:0]       xfer_cnt;
    logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, xfer_cnt,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, xfer_cnt,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS wait cycles; expired flags the LIMIT-th consecutive wait cycle.
module apb_timeout_cnt #(
    parameter int LIMIT = 256
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : enable ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    assign expired = enable && (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command stream to APB3 SETUP/ACCESS transfers, one outstanding.
// Optional APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait states.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic             PCLK,
    input logic             PRESETn,
    apb_cmd_master_if.master bus
);
    import apb_pkg::*;
    apb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic              pwrite_q, pwrite_d, err_q, err_d, tmo_q, tmo_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              expired;
`ifdef APB_TIMEOUT_EN
    apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (state_q == SETUP),
        .enable  (state_q == ACCESS && !bus.PREADY),
        .expired (expired)
    );
`else
    logic unused_tmo;
    assign unused_tmo = TIMEOUT_CYCLES != 0;
    assign expired    = 1'b0;
`endif
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                state_d  = SETUP;
                paddr_d  = bus.cmd_addr;
                pwrite_d = bus.cmd_write;
                pwdata_d = bus.cmd_wdata;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (bus.PREADY) begin
                state_d = RESP;
                rdata_d = pwrite_q ? '0 : bus.PRDATA;
                err_d   = bus.PSLVERR;
                tmo_d   = 1'b0;
            end else if (expired) begin
                state_d = RESP;
                rdata_d = '0;
                err_d   = APB_ERR;
                tmo_d   = 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
                state_d = IDLE;
                cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= APB_OK;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    assign bus.cmd_ready   = state_q == IDLE;
    assign bus.PSEL        = state_q == SETUP || state_q == ACCESS;
    assign bus.PENABLE     = state_q == ACCESS;
    assign bus.PADDR       = paddr_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = state_q == RESP;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = tmo_q;
    assign bus.xfer_cnt    = cnt_q;
endmodule
